// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the Q6.10 datapath: default format,
// saturation limits, the signed sample type and the divider state encoding.
package fxp_pkg;

    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 10;

    localparam logic [FXP_WIDTH-1:0] Q_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] Q_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/fxp_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude if it fits.
module fxp_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // rem_i < dmag_i <= 2^(WIDTH-1), so the extra top bit is a clean borrow flag
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {2'b00, dmag_i};
    assign qbit_o  = ~trial[WIDTH+1];
    assign rem_o   = qbit_o ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider Q = N / D, one quotient bit per clock.
// Define FXP_DIV_SAT_EN to clamp overflowing quotients instead of wrapping.
module fxp_div_seq
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             ovf,
    output logic             dz,
    output logic [1:0]       dbg_state_o
);

    localparam int ITER = WIDTH + FRAC;
    localparam int CW   = $clog2(ITER);

    localparam logic [WIDTH-1:0] SAT_POS     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ITER-1:0]  MAG_POS_MAX = ITER'(SAT_POS);
    localparam logic [ITER-1:0]  MAG_NEG_MAX = ITER'(SAT_NEG);

    // Handshake: an input is taken on a rising edge where in_valid & in_ready
    // (in_ready only in IDLE); a result is held with out_valid until a rising
    // edge where out_valid & out_ready, after which the block returns to IDLE.

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ITER-1:0]  quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rem_next;
    logic             qbit;
    logic [WIDTH-1:0] n_mag;
    logic [WIDTH-1:0] d_mag;
    logic [WIDTH-1:0] q_low;
    logic [WIDTH-1:0] q_wrap;
    logic [WIDTH-1:0] q_fix;
    logic             ovf_fix;

    fxp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[ITER-1]),
        .dmag_i (dmag_q),
        .rem_o  (rem_next),
        .qbit_o (qbit)
    );

    assign n_mag = N[WIDTH-1] ? (~N + 1'b1) : N;
    assign d_mag = D[WIDTH-1] ? (~D + 1'b1) : D;

    // The low bits of a two's complement negation depend only on the low bits
    assign q_low   = quo_q[WIDTH-1:0];
    assign q_wrap  = sign_q ? (~q_low + 1'b1) : q_low;
    assign ovf_fix = sign_q ? (quo_q > MAG_NEG_MAX) : (quo_q > MAG_POS_MAX);

`ifdef FXP_DIV_SAT_EN
    assign q_fix = ovf_fix ? (sign_q ? SAT_NEG : SAT_POS) : q_wrap;
`else
    assign q_fix = q_wrap;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        sign_d  = sign_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (D == '0) begin
                        q_d     = N[WIDTH-1] ? SAT_NEG : SAT_POS;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        sign_d  = N[WIDTH-1] ^ D[WIDTH-1];
                        quo_d   = ITER'(n_mag) << FRAC;
                        rem_d   = '0;
                        dmag_d  = d_mag;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // quo_q shifts dividend bits out the top and quotient bits in the bottom
                rem_d = rem_next;
                quo_d = {quo_q[ITER-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_d     = q_fix;
                ovf_d   = ovf_fix;
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            sign_q  <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dmag_q  <= dmag_d;
            sign_q  <= sign_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign Q           = q_q;
    assign ovf         = ovf_q;
    assign dz          = dz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed bench for fxp_div_seq (Q6.10); expected quotients are hand-computed.
// Define FXP_DIV_SAT_EN here too when building the saturating variant.
module tb_fxp_div_seq;
    import fxp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n_in;
    logic [15:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q_out;
    logic        ovf_out;
    logic        dz_out;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    fxp_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .N           (n_in),
        .D           (d_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Q           (q_out),
        .ovf         (ovf_out),
        .dz          (dz_out),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operand pair starting #1 after a rising edge; lat counts the
    // rising edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [15:0] n, input logic [15:0] d,
                          output logic [15:0] q, output logic o_ovf,
                          output logic o_dz, output int lat);
        check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        n_in     = n;
        d_in     = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q     = q_out;
        o_ovf = ovf_out;
        o_dz  = dz_out;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_release", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_release", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] q_r;
        logic        ovf_r;
        logic        dz_r;
        int          lat_r;
        logic [15:0] want;

        vecs[0]  = '{16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0, 27};
        vecs[1]  = '{16'hFC00, 16'h1000, 16'hFF00, 1'b0, 1'b0, 27};
        vecs[2]  = '{16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, 27};
        vecs[3]  = '{16'hFC00, 16'h0C00, 16'hFEAB, 1'b0, 1'b0, 27};
        vecs[4]  = '{16'hF400, 16'hF800, 16'h0600, 1'b0, 1'b0, 27};
        vecs[5]  = '{16'h8000, 16'h8000, 16'h0400, 1'b0, 1'b0, 27};
        vecs[6]  = '{16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0, 27};
        vecs[7]  = '{16'h7FFF, 16'h0400, 16'h7FFF, 1'b0, 1'b0, 27};
        vecs[8]  = '{16'h0001, 16'h0800, 16'h0000, 1'b0, 1'b0, 27};
`ifdef FXP_DIV_SAT_EN
        vecs[9]  = '{16'h7C00, 16'h0040, 16'h7FFF, 1'b1, 1'b0, 27};
        vecs[10] = '{16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 1'b0, 27};
        vecs[11] = '{16'h8000, 16'h0200, 16'h8000, 1'b1, 1'b0, 27};
`else
        vecs[9]  = '{16'h7C00, 16'h0040, 16'hC000, 1'b1, 1'b0, 27};
        vecs[10] = '{16'h8000, 16'hFC00, 16'h8000, 1'b1, 1'b0, 27};
        vecs[11] = '{16'h8000, 16'h0200, 16'h0000, 1'b1, 1'b0, 27};
`endif
        vecs[12] = '{16'hF800, 16'h0000, Q_MIN, 1'b0, 1'b1, 0};
        vecs[13] = '{16'h0000, 16'h0000, Q_MAX, 1'b0, 1'b1, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        d_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_q", {16'b0, q_out}, 32'd0);
        check("reset_ovf", {31'b0, ovf_out}, 32'd0);
        check("reset_dz", {31'b0, dz_out}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i].q);
            run_op(vecs[i].n, vecs[i].d, q_r, ovf_r, dz_r, lat_r);
            want = exp_q.pop_front();
            check($sformatf("vec%0d_q", i), {16'b0, q_r}, {16'b0, want});
            check($sformatf("vec%0d_ovf", i), {31'b0, ovf_r}, {31'b0, vecs[i].ovf});
            check($sformatf("vec%0d_dz", i), {31'b0, dz_r}, {31'b0, vecs[i].dz});
            check($sformatf("vec%0d_latency", i), lat_r, vecs[i].lat);
            release_out();
        end

        // result held under backpressure; in_valid ignored while busy
        run_op(16'h0C00, 16'h0800, q_r, ovf_r, dz_r, lat_r);
        check("hold_first_q", {16'b0, q_r}, 32'h0600);
        n_in     = 16'h0400;
        d_in     = 16'h0400;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold%0d_q", c), {16'b0, q_out}, 32'h0600);
            check($sformatf("hold%0d_flags", c), {30'b0, ovf_out, dz_out}, 32'd0);
            check($sformatf("hold%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_cycle_not_accepted", {31'b0, in_ready}, 32'd1);
        check("release_cycle_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("next_op_accepted", {31'b0, in_ready}, 32'd0);
        lat_r = 0;
        while (!out_valid && lat_r < 100) begin
            @(posedge clk);
            #1;
            lat_r++;
        end
        check("next_op_latency", lat_r, 27);
        check("next_op_q", {16'b0, q_out}, 32'h0400);
        release_out();

        // asynchronous reset in the middle of CALC
        n_in     = 16'h0C00;
        d_in     = 16'h0800;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_calc_state", {30'b0, dbg_state}, 32'd1);
        rst = 1'b1;
        #2;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_q", {16'b0, q_out}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_state", {30'b0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(16'h0400, 16'h0400, q_r, ovf_r, dz_r, lat_r);
        check("post_reset_q", {16'b0, q_r}, 32'h0400);
        check("post_reset_flags", {30'b0, ovf_r, dz_r}, 32'd0);
        check("post_reset_latency", lat_r, 27);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
